lif_membrane_state: RTL and testbench

Holds the neuron's membrane potential register between time steps. It sits directly downstream of the membrane-potential accumulator and closes the loop back to it.
- Each step it captures the accumulator's new potential and compares it against the threshold to fire a spike.
- It returns three values to the accumulator for the next step: leaked potential beta_u, minus_teta and was_spike.
- Leak is shift-based: beta = 1 - 2^-beta_shift.

---
 rtl/lif_membrane_state.sv | 121 ++++++++++++
 tb/tb_lif_membrane_state.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_membrane_state.sv
// LIF neuron membrane register: captures u(t), fires against theta, and feeds back beta*u, -theta and the last spike.
// Optional REFRACTORY_EN adds a READY/REFRACT FSM that zeroes and silences the neuron for refr_steps steps.
module lif_membrane_state #(
    parameter int N_STAGE   = 6,
    parameter int THETA_RST = 64,
    parameter int SHIFT_RST = 2,
    localparam int W        = N_STAGE + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         step_valid,
    input  logic [W-1:0] u_in,
    input  logic         cfg_load,
    input  logic [W-1:0] theta,
    input  logic [2:0]   beta_shift,
`ifdef REFRACTORY_EN
    input  logic [3:0]   refr_steps,
    output logic         refractory,
`endif
    output logic [W-1:0] beta_u,
    output logic [W-1:0] minus_teta,
    output logic         was_spike,
    output logic         spike,
    output logic [W-1:0] u_state,
    output logic [7:0]   spike_count
);

    logic signed [W-1:0] u_reg;
    logic signed [W-1:0] theta_reg;
    logic signed [W-1:0] u_in_s;
    logic signed [W-1:0] leak_term;
    logic [2:0]          shift_reg;
    logic                spike_reg;
    logic                spike_q;
    logic [7:0]          cnt_q;
    logic                step;
    logic                fire_raw;
    logic                fire;
    logic                suppress;

    assign u_in_s   = u_in;
    assign step     = ena & step_valid;
    // Always compares against the registered theta, so a same-cycle cfg_load only affects later steps.
    assign fire_raw = (u_in_s >= theta_reg);

`ifdef REFRACTORY_EN
    typedef enum logic {READY = 1'b0, REFRACT = 1'b1} state_t;
    state_t     state, state_nx;
    logic [3:0] rcnt, rcnt_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= READY;
            rcnt  <= 4'd0;
        end else if (step) begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        case (state)
            READY: begin
                if (fire_raw && (refr_steps != 4'd0)) begin
                    state_nx = REFRACT;
                    rcnt_nx  = refr_steps;
                end
            end
            REFRACT: begin
                rcnt_nx = rcnt - 4'd1;
                if (rcnt == 4'd1) state_nx = READY;
            end
            default: state_nx = READY;
        endcase
    end

    always_comb begin
        refractory = (state == REFRACT);
        suppress   = refractory;
    end
`else
    assign suppress = 1'b0;
`endif

    assign fire = fire_raw & ~suppress;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_reg     <= '0;
            spike_reg <= 1'b0;
            spike_q   <= 1'b0;
            cnt_q     <= 8'd0;
            theta_reg <= THETA_RST[W-1:0];
            shift_reg <= SHIFT_RST[2:0];
        end else if (ena) begin
            spike_q <= step & fire;
            if (step) begin
                u_reg     <= suppress ? '0 : u_in_s;
                spike_reg <= fire;
                if (fire && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
            end
            if (cfg_load) begin
                theta_reg <= theta;
                shift_reg <= beta_shift;
            end
        end
    end

    // Arithmetic shift: large shifts of a negative u leave -1, so the leak never fully reaches u.
    assign leak_term   = u_reg >>> shift_reg;
    assign beta_u      = u_reg - leak_term;
    assign minus_teta  = -theta_reg;
    assign was_spike   = spike_reg;
    assign spike       = spike_q & ena;
    assign u_state     = u_reg;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_membrane_state.sv
// Bench for lif_membrane_state: integer reference model checked every cycle plus literal test-plan values.
// Build with +define+REFRACTORY_EN to also cover the refractory period.
module tb_lif_membrane_state;
    localparam int N_STAGE = 6;
    localparam int W       = N_STAGE + 2;

    logic         clk = 1'b0;
    logic         rst_n, ena, step_valid, cfg_load;
    logic [W-1:0] u_in, theta;
    logic [2:0]   beta_shift;
    logic [W-1:0] beta_u, minus_teta, u_state;
    logic         was_spike, spike;
    logic [7:0]   spike_count;
`ifdef REFRACTORY_EN
    logic [3:0]   refr_steps;
    logic         refractory;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    lif_membrane_state #(.N_STAGE(N_STAGE), .THETA_RST(64), .SHIFT_RST(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step_valid(step_valid), .u_in(u_in),
        .cfg_load(cfg_load), .theta(theta), .beta_shift(beta_shift),
`ifdef REFRACTORY_EN
        .refr_steps(refr_steps), .refractory(refractory),
`endif
        .beta_u(beta_u), .minus_teta(minus_teta), .was_spike(was_spike), .spike(spike),
        .u_state(u_state), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, rules applied as stated.
    int m_u, m_theta, m_shift, m_cnt, m_rcnt;
    bit m_was, m_pulse, m_refr;

    always @(posedge clk) begin
        int  uin;
        bit  f;
        uin = $signed(u_in);
        if (!rst_n) begin
            m_u = 0; m_was = 0; m_pulse = 0; m_cnt = 0;
            m_theta = 64; m_shift = 2; m_refr = 0; m_rcnt = 0;
        end else if (ena) begin
            m_pulse = 0;
            if (step_valid) begin
                if (m_refr) begin
                    m_u = 0; m_was = 0;
                    m_rcnt = m_rcnt - 1;
                    if (m_rcnt == 0) m_refr = 0;
                end else begin
                    f = (uin >= m_theta);
                    m_u = uin; m_was = f; m_pulse = f;
                    if (f && m_cnt < 255) m_cnt = m_cnt + 1;
`ifdef REFRACTORY_EN
                    if (f && refr_steps != 0) begin
                        m_refr = 1; m_rcnt = refr_steps;
                    end
`endif
                end
            end
            if (cfg_load) begin
                m_theta = $signed(theta);
                m_shift = beta_shift;
            end
        end
    end

    function automatic int floor_shift(int u, int s);
        int d;
        d = 1 << s;
        return (u >= 0) ? (u / d) : -(((-u) + d - 1) / d);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [W-1:0] e_beta, e_mt, e_u;
        if (chk_en) begin
            e_u    = m_u;
            e_beta = (m_shift == 0) ? 0 : (m_u - floor_shift(m_u, m_shift));
            e_mt   = -m_theta;
            check("model_u_state", 16'(u_state), 16'(e_u));
            check("model_beta_u", 16'(beta_u), 16'(e_beta));
            check("model_minus_teta", 16'(minus_teta), 16'(e_mt));
            check("model_was_spike", 16'(was_spike), 16'(m_was));
            check("model_spike", 16'(spike), 16'(m_pulse && ena));
            check("model_spike_count", 16'(spike_count), 16'(m_cnt));
`ifdef REFRACTORY_EN
            check("model_refractory", 16'(refractory), 16'(m_refr));
`endif
        end
    end

    // Inputs change 2 time units after the active edge; literal checks run at the following negedge.
    task automatic cyc();
        @(posedge clk);
        #2;
        step_valid = 1'b0;
        cfg_load   = 1'b0;
    endtask

    task automatic do_step(input int u);
        step_valid = 1'b1;
        u_in       = u[W-1:0];
        cyc();
    endtask

    task automatic do_cfg(input int th, input int sh, input bit with_step, input int u);
        cfg_load   = 1'b1;
        theta      = th[W-1:0];
        beta_shift = sh[2:0];
        step_valid = with_step;
        u_in       = u[W-1:0];
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; step_valid = 1'b0; cfg_load = 1'b0;
        u_in = '0; theta = 8'd64; beta_shift = 3'd2;
`ifdef REFRACTORY_EN
        refr_steps = 4'd0;
`endif
        cyc(); cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_u_state", 16'(u_state), 16'h0);
        check("rst_beta_u", 16'(beta_u), 16'h0);
        check("rst_was_spike", 16'(was_spike), 16'h0);
        check("rst_minus_teta", 16'(minus_teta), 16'hC0);
        check("rst_spike_count", 16'(spike_count), 16'h0);

        // Leak with shift 2, then shift 1 loaded alongside a step.
        do_step(96);
        @(negedge clk);
        check("leak_u_state", 16'(u_state), 16'd96);
        check("leak_beta_u", 16'(beta_u), 16'd72);
        check("leak_spike", 16'(spike), 16'd1);
        check("leak_was_spike", 16'(was_spike), 16'd1);
        do_cfg(64, 1, 1'b1, -32);
        @(negedge clk);
        check("leak_neg_beta_u", 16'(beta_u), 16'(8'hF0));
        check("leak_neg_spike", 16'(spike), 16'd0);
        check("leak_neg_was_spike", 16'(was_spike), 16'd0);
        do_cfg(64, 2, 1'b0, 0);

        // Threshold edge and held was_spike.
        do_step(63);
        @(negedge clk);
        check("thr63_spike", 16'(spike), 16'd0);
        do_step(64);
        @(negedge clk);
        check("thr64_spike", 16'(spike), 16'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            check("thr64_pulse_end", 16'(spike), 16'd0);
            check("thr64_was_held", 16'(was_spike), 16'd1);
        end

        // Same-cycle cfg: compare uses old theta.
        do_cfg(100, 2, 1'b1, 80);
        @(negedge clk);
        check("cfg_old_theta_fire", 16'(spike), 16'd1);
        check("cfg_minus_teta", 16'(minus_teta), 16'h9C);
        do_step(80);
        @(negedge clk);
        check("cfg_new_theta_nofire", 16'(spike), 16'd0);

        // Saturation, then ena low right after a firing step.
        for (int i = 0; i < 300; i++) do_step(100 + (i % 28));
        @(negedge clk);
        check("sat_count", 16'(spike_count), 16'd255);
        do_step(127);
        ena = 1'b0; step_valid = 1'b1; cfg_load = 1'b1; u_in = 8'd5; theta = 8'd10; beta_shift = 3'd0;
        @(negedge clk);
        check("ena0_spike", 16'(spike), 16'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("ena0_u_hold", 16'(u_state), 16'd127);
        check("ena0_mt_hold", 16'(minus_teta), 16'h9C);
        check("ena0_count_hold", 16'(spike_count), 16'd255);
        check("ena0_was_hold", 16'(was_spike), 16'd1);
        ena = 1'b1; step_valid = 1'b0; cfg_load = 1'b0;

        // Shift extremes and theta wrap.
        do_cfg(-128, 0, 1'b1, 50);
        @(negedge clk);
        check("shift0_beta_u", 16'(beta_u), 16'd0);
        check("wrap_minus_teta", 16'(minus_teta), 16'h80);
        do_cfg(-128, 7, 1'b1, -5);
        @(negedge clk);
        check("shift7_neg_beta_u", 16'(beta_u), 16'(8'hFC));
        do_step(100);
        @(negedge clk);
        check("shift7_pos_beta_u", 16'(beta_u), 16'd100);
        for (int i = 0; i < 12; i++) do_step($urandom_range(0, 255));
        do_cfg(64, 2, 1'b0, 0);

`ifdef REFRACTORY_EN
        refr_steps = 4'd2;
        do_step(120);
        @(negedge clk);
        check("refr_enter", 16'(refractory), 16'd1);
        do_step(120);
        @(negedge clk);
        check("refr1_spike", 16'(spike), 16'd0);
        check("refr1_u_state", 16'(u_state), 16'd0);
        check("refr1_refractory", 16'(refractory), 16'd1);
        do_step(120);
        @(negedge clk);
        check("refr2_spike", 16'(spike), 16'd0);
        check("refr2_refractory", 16'(refractory), 16'd0);
        refr_steps = 4'd0;
        do_step(120);
        @(negedge clk);
        check("refr3_spike", 16'(spike), 16'd1);
        check("refr3_refractory", 16'(refractory), 16'd0);
        refr_steps = 4'd3;
        do_step(120);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("refr_reset", 16'(refractory), 16'd0);
        refr_steps = 4'd0;
`endif
        cyc();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
